// File: rtl/pc_update_unit_pkg.sv
// Shared encodings for the PC update unit: branch conditions, exception codes,
// exception-sequencer states and the default exception-vector base address.
package pc_update_unit_pkg;

   typedef enum logic [1:0] {
      BR_BEQ = 2'b00,
      BR_BNE = 2'b01,
      BR_BLE = 2'b10,
      BR_BGT = 2'b11
   } branch_op_e;

   typedef enum logic [1:0] {
      EXC_INVALID_OP = 2'b00,
      EXC_OVERFLOW   = 2'b01,
      EXC_DIV_ZERO   = 2'b10,
      EXC_RESERVED   = 2'b11
   } exc_code_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SAVE  = 2'b01,
      ST_FETCH = 2'b10,
      ST_LOAD  = 2'b11
   } state_e;

   localparam logic [31:0] VEC_BASE_DEFAULT = 32'd253;
   localparam logic [31:0] EPC_OFFSET       = 32'd4;

endpackage

// File: rtl/pc_update_unit_branch_cond_eval.sv
// Combinational branch-condition evaluation from the ALU zero/greater-than flags.
module branch_cond_eval
   import pc_update_unit_pkg::*;
(
   input  logic [1:0] branch_op_i,
   input  logic       zero_i,
   input  logic       gt_i,
   output logic       taken_o
);

   always_comb begin
      taken_o = 1'b0;
      case (branch_op_e'(branch_op_i))
         BR_BEQ:  taken_o = zero_i;
         BR_BNE:  taken_o = !zero_i;
         BR_BLE:  taken_o = zero_i | !gt_i;
         BR_BGT:  taken_o = gt_i & !zero_i;
         default: taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_update_unit.sv
// Program-counter register with branch-conditional update and a small
// exception sequencer that saves the faulting PC and fetches a one-byte vector.
module pc_update_unit
   import pc_update_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] VEC_BASE = VEC_BASE_DEFAULT
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_next,
   input  logic        pc_write,
   input  logic        pc_write_cond,
   input  logic [1:0]  branch_op,
   input  logic        zero,
   input  logic        gt,
   input  logic        exc_req,
   input  logic [1:0]  exc_code,
   input  logic [7:0]  vec_data,
   output logic [31:0] pc,
   output logic [31:0] epc,
   output logic [31:0] vec_addr,
   output logic        vec_rd,
   output logic        exc_busy,
   output logic        branch_taken
);

   state_e      state_q,    state_d;
   exc_code_e   code_q,     code_d;
   logic [31:0] pc_q,       pc_d;
   logic [31:0] epc_q,      epc_d;
   logic [31:0] vec_addr_q, vec_addr_d;
   logic        vec_rd_q,   vec_rd_d;

   branch_cond_eval u_branch_cond_eval (
      .branch_op_i (branch_op),
      .zero_i      (zero),
      .gt_i        (gt),
      .taken_o     (branch_taken)
   );

   // The vector read strobe/address are set on entry to FETCH so they are
   // registered outputs that are valid for exactly the FETCH cycle.
   always_comb begin
      state_d    = state_q;
      code_d     = code_q;
      pc_d       = pc_q;
      epc_d      = epc_q;
      vec_rd_d   = 1'b0;
      vec_addr_d = 32'd0;
      case (state_q)
         ST_IDLE: begin
            if (exc_req && (exc_code_e'(exc_code) != EXC_RESERVED)) begin
               state_d = ST_SAVE;
               code_d  = exc_code_e'(exc_code);
            end else if (pc_write || (pc_write_cond && branch_taken)) begin
               pc_d = pc_next;
            end
         end
         ST_SAVE: begin
            epc_d      = pc_q - EPC_OFFSET;
            state_d    = ST_FETCH;
            vec_rd_d   = 1'b1;
            vec_addr_d = VEC_BASE + {30'd0, code_q};
         end
         ST_FETCH: begin
            state_d = ST_LOAD;
         end
         ST_LOAD: begin
            pc_d    = {24'd0, vec_data};
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         code_q     <= EXC_INVALID_OP;
         pc_q       <= RESET_PC;
         epc_q      <= 32'd0;
         vec_rd_q   <= 1'b0;
         vec_addr_q <= 32'd0;
      end else begin
         state_q    <= state_d;
         code_q     <= code_d;
         pc_q       <= pc_d;
         epc_q      <= epc_d;
         vec_rd_q   <= vec_rd_d;
         vec_addr_q <= vec_addr_d;
      end
   end

   assign pc       = pc_q;
   assign epc      = epc_q;
   assign vec_rd   = vec_rd_q;
   assign vec_addr = vec_addr_q;
   assign exc_busy = (state_q != ST_IDLE);

endmodule

// File: doc/pc_update_unit.md
PC_UPDATE_UNIT -- requirements
Module: pc_update_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, value loaded into pc on reset.
REQ-002 The block SHALL have parameter VEC_BASE, default 32'd253, byte address of the first exception-vector entry.
REQ-003 The block SHALL have port clk, input, 1, the single clock; every register SHALL update on its rising edge.
REQ-004 The block SHALL have port reset, input, 1; reset is asynchronous and active-low.
REQ-005 The block SHALL have port pc_next, input, 32, next-PC candidate from the PC-source selection mux.
REQ-006 The block SHALL have port pc_write, input, 1, unconditional PC write enable.
REQ-007 The block SHALL have port pc_write_cond, input, 1, conditional (branch) PC write enable.
REQ-008 The block SHALL have port branch_op, input, 2, branch condition: 00 beq, 01 bne, 10 ble, 11 bgt.
REQ-009 The block SHALL have port zero, input, 1, ALU equality flag.
REQ-010 The block SHALL have port gt, input, 1, ALU greater-than flag.
REQ-011 The block SHALL have port exc_req, input, 1, exception request strobe.
REQ-012 The block SHALL have port exc_code, input, 2: 00 invalid opcode, 01 overflow, 10 divide-by-zero, 11 reserved.
REQ-013 The block SHALL have port vec_data, input, 8, byte read from memory at vec_addr.
REQ-014 The block SHALL have port pc, output, 32, current program counter.
REQ-015 The block SHALL have port epc, output, 32, exception program counter.
REQ-016 The block SHALL have port vec_addr, output, 32, vector-fetch memory address.
REQ-017 The block SHALL have port vec_rd, output, 1, vector-fetch read strobe.
REQ-018 The block SHALL have port exc_busy, output, 1, high whenever the FSM is not in IDLE.
REQ-019 The block SHALL have port branch_taken, output, 1, combinational result of the branch-condition evaluation.

Function
REQ-020 branch_taken SHALL equal: beq zero; bne !zero; ble (zero | !gt); bgt (gt & !zero).
REQ-021 In IDLE with exc_req low, pc SHALL load pc_next on the edge where pc_write, or pc_write_cond & branch_taken, is high; otherwise pc SHALL hold.
REQ-022 FSM states SHALL be IDLE, SAVE, FETCH, LOAD; the encoding is 2 bits.
REQ-023 IDLE->SAVE SHALL occur when exc_req is high and exc_code != 11; exc_code 11 SHALL be ignored, with normal PC behaviour.
REQ-024 In IDLE, an accepted exc_req SHALL take priority over pc_write and pc_write_cond; pc SHALL NOT update on that edge.
REQ-025 The block SHALL latch exc_code on the IDLE->SAVE edge.
REQ-026 In SAVE, epc SHALL load pc - 32'd4 (mod 2^32); the FSM SHALL then go to FETCH.
REQ-027 In FETCH, vec_rd SHALL be 1 and vec_addr SHALL be VEC_BASE + latched code; the FSM SHALL then go to LOAD.
REQ-028 Memory latency SHALL be 1 cycle: vec_data is valid in LOAD, and pc SHALL load {24'b0, vec_data} on the LOAD->IDLE edge.
REQ-029 While exc_busy is high, pc_write, pc_write_cond and exc_req SHALL be ignored, with no queuing.
REQ-030 vec_rd SHALL be 0 outside FETCH, and vec_addr SHALL be 0 outside FETCH.
REQ-031 Exception latency SHALL be 4 edges from request acceptance to the vector being in pc; exc_busy SHALL be high for exactly 3 cycles.

Reset
REQ-032 Reset assertion SHALL force, asynchronously, pc = RESET_PC, epc = 0, FSM = IDLE, latched code = 0, vec_rd = 0 and vec_addr = 0, including mid-exception.
REQ-033 After reset deasserts, the first active edge SHALL behave as IDLE.

Structure
REQ-034 A shared package SHALL hold the branch_op encodings, the exc_code encodings, the FSM state typedef/constants and the VEC_BASE default.
REQ-035 The branch-condition logic SHALL be a combinational sub-module, branch_cond_eval.

Verification
REQ-036 The bench SHALL check: pc = 0x40, pc_next = 0x44, pc_write = 1 -> pc = 0x44 after 1 edge.
REQ-037 The bench SHALL check: pc_write_cond = 1, branch_op = 01, zero = 1, pc_next = 0x80 -> branch_taken = 0 and pc holds; with zero = 0 -> pc = 0x80.
REQ-038 The bench SHALL check: pc = 0x100, exc_req = 1, exc_code = 01, vec_data = 0x3C -> epc = 0xFC, vec_rd pulses with vec_addr = 254, pc = 0x3C after 4 edges.
REQ-039 The bench SHALL check: exc_req and pc_write high together in IDLE -> the exception is taken and pc does not take pc_next.
REQ-040 The bench SHALL check: reset asserted in FETCH -> pc = RESET_PC, epc = 0, exc_busy = 0 immediately, with no clock edge needed.
REQ-041 The bench SHALL check: exc_code = 11 with pc_write = 1 -> no exception is taken and pc loads pc_next.
